// File: rtl/block_data_memory.sv
// ---------------------------------------------------------------------------
// block_data_memory
//
// Slow, word-organised data memory that answers the data cache's block
// transfer requests (responder side of mem_READ / mem_WRITE / mem_BUSYWAIT).
// Each access costs a fixed latency during which BUSYWAIT stays high. A one
// cycle DONE state follows every access. In DONE, BUSYWAIT is low and the
// request lines are ignored, because the cache keeps driving its request for
// one cycle after busywait falls.
//
// Ports:
//   CLK        in   1   clock, all state updates on posedge
//   RESET      in   1   synchronous, active-high reset (clears all words)
//   READ       in   1   block read request
//   WRITE      in   1   block write request
//   ADDRESS    in   6   block address {tag, index}
//   WRITEDATA  in  32   write block, byte0 = [31:24] ... byte3 = [7:0]
//   READDATA   out 32   read block, valid from DONE, held until next read
//   BUSYWAIT   out  1   high while a request is pending
//   ERR        out  1   one-cycle pulse when READ and WRITE are both high in IDLE
//
// Parameters:
//   LATENCY    BUSY-state cycles per access (1..15)
//   DEPTH      number of 32-bit blocks, must equal 2**6
// ---------------------------------------------------------------------------
module block_data_memory #(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [5:0]  ADDRESS,
  input  logic [31:0] WRITEDATA,
  output logic [31:0] READDATA,
  output logic        BUSYWAIT,
  output logic        ERR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter load value: BUSY lasts LATENCY cycles, counting LATENCY-1 down to 0.
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  state_t      state_r;
  logic [3:0]  count_r;
  logic        op_write_r;
  logic [5:0]  addr_r;
  logic [31:0] wdata_r;
  logic [31:0] mem_r [DEPTH];
  logic        last_cycle_s;
  logic        mem_we_s;

  // Final BUSY cycle of an access, and whether it commits a write.
  always_comb begin
    last_cycle_s = 1'b0;
    mem_we_s     = 1'b0;
    if (state_r == ST_BUSY && count_r == 4'd0) begin
      last_cycle_s = 1'b1;
      mem_we_s     = op_write_r;
    end else begin
      last_cycle_s = 1'b0;
      mem_we_s     = 1'b0;
    end
  end

  // Busywait: combinational in IDLE so the cache sees it in the request cycle.
  always_comb begin
    BUSYWAIT = 1'b0;
    if (RESET) begin
      BUSYWAIT = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: BUSYWAIT = READ ^ WRITE;
        ST_BUSY: BUSYWAIT = 1'b1;
        ST_DONE: BUSYWAIT = 1'b0;
        default: BUSYWAIT = 1'b0;
      endcase
    end
  end

  // Access sequencer: latches the request, counts latency, returns read data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      count_r    <= 4'd0;
      op_write_r <= 1'b0;
      addr_r     <= 6'd0;
      wdata_r    <= 32'h0;
      READDATA   <= 32'h0;
      ERR        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Conflicting request: flag it, start nothing.
          ERR <= READ & WRITE;
          if (READ ^ WRITE) begin
            op_write_r <= WRITE;
            addr_r     <= ADDRESS;
            wdata_r    <= WRITEDATA;
            count_r    <= LAT_LOAD;
            state_r    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          ERR <= 1'b0;
          if (last_cycle_s) begin
            if (!op_write_r) begin
              READDATA <= mem_r[addr_r];
            end
            state_r <= ST_DONE;
          end else begin
            count_r <= count_r - 4'd1;
          end
        end
        ST_DONE: begin
          ERR     <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ERR     <= 1'b0;
          count_r <= 4'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Block storage: cleared on reset; a write commits only at the end of BUSY,
  // so a reset during the access drops it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0;
      end
    end else if (mem_we_s) begin
      mem_r[addr_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// Bench for block_data_memory: a LATENCY=5 instance and a LATENCY=1 instance
// share the request lines; the idle one is held in reset. Stimulus pushes the
// expected busy length and read data into a queue per instance; a monitor per
// instance pops and compares each time BUSYWAIT falls after a busy window.
module tb_block_data_memory;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          busy;
  } exp_t;

  logic        clk_s;
  logic        rst0_s;
  logic        rst1_s;
  logic        read_s;
  logic        write_s;
  logic [5:0]  addr_s;
  logic [31:0] wdata_s;
  logic [31:0] rdata0_s;
  logic [31:0] rdata1_s;
  logic        bw0_s;
  logic        bw1_s;
  logic        err0_s;
  logic        err1_s;
  logic        sel_s;
  logic        bw_s;

  int checks;
  int errors;
  exp_t q0[$];
  exp_t q1[$];
  int bc0;
  int bc1;

  assign bw_s = sel_s ? bw1_s : bw0_s;

  block_data_memory #(.LATENCY(5), .DEPTH(64)) dut (
    .CLK(clk_s), .RESET(rst0_s), .READ(read_s), .WRITE(write_s),
    .ADDRESS(addr_s), .WRITEDATA(wdata_s), .READDATA(rdata0_s),
    .BUSYWAIT(bw0_s), .ERR(err0_s)
  );

  block_data_memory #(.LATENCY(1), .DEPTH(64)) dut1 (
    .CLK(clk_s), .RESET(rst1_s), .READ(read_s), .WRITE(write_s),
    .ADDRESS(addr_s), .WRITEDATA(wdata_s), .READDATA(rdata1_s),
    .BUSYWAIT(bw1_s), .ERR(err1_s)
  );

  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the LATENCY=5 instance.
  always @(negedge clk_s) begin
    exp_t e;
    if (rst0_s) begin
      bc0 = 0;
    end else if (bw0_s) begin
      bc0 = bc0 + 1;
    end else if (bc0 != 0) begin
      if (q0.size() == 0) begin
        chk("unexpected_completion_l5", 32'(bc0), 32'd0);
      end else begin
        e = q0.pop_front();
        chk("busy_cycles_l5", 32'(bc0), 32'(e.busy));
        if (e.rd) chk("readdata_l5", rdata0_s, e.data);
      end
      bc0 = 0;
    end
  end

  // Monitor for the LATENCY=1 instance.
  always @(negedge clk_s) begin
    exp_t e;
    if (rst1_s) begin
      bc1 = 0;
    end else if (bw1_s) begin
      bc1 = bc1 + 1;
    end else if (bc1 != 0) begin
      if (q1.size() == 0) begin
        chk("unexpected_completion_l1", 32'(bc1), 32'd0);
      end else begin
        e = q1.pop_front();
        chk("busy_cycles_l1", 32'(bc1), 32'(e.busy));
        if (e.rd) chk("readdata_l1", rdata1_s, e.data);
      end
      bc1 = 0;
    end
  end

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  // Present a request now; optionally register the expected completion.
  task automatic start(input logic rd, input logic wr, input logic [5:0] a,
                       input logic [31:0] d, input logic push, input logic [31:0] exp_data);
    exp_t e;
    read_s  = rd;
    write_s = wr;
    addr_s  = a;
    wdata_s = d;
    if (push) begin
      e.rd   = rd;
      e.data = exp_data;
      e.busy = sel_s ? 2 : 6;
      if (sel_s) q1.push_back(e);
      else       q0.push_back(e);
    end
  endtask

  // Advance until BUSYWAIT is low (the DONE cycle), with a cycle budget.
  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bw_s) break;
    end
    if (bw_s) chk("wait_done_timeout", 32'(bw_s), 32'd0);
  endtask

  // Drop the request in DONE and step into IDLE.
  task automatic release_req();
    read_s  = 1'b0;
    write_s = 1'b0;
    tick();
  endtask

  task automatic access(input logic rd, input logic [5:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data);
    start(rd, ~rd, a, d, 1'b1, exp_data);
    wait_done();
    release_req();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    bc0     = 0;
    bc1     = 0;
    sel_s   = 1'b0;
    rst0_s  = 1'b1;
    rst1_s  = 1'b1;
    read_s  = 1'b0;
    write_s = 1'b0;
    addr_s  = 6'd0;
    wdata_s = 32'h0;

    // Reset state
    #1;
    chk("busywait_in_reset", 32'(bw0_s), 32'd0);
    tick();
    tick();
    rst0_s = 1'b0;
    #1;
    chk("reset_busywait", 32'(bw0_s), 32'd0);
    chk("reset_readdata", rdata0_s, 32'h0);
    chk("reset_err", 32'(err0_s), 32'd0);

    // Read of a cleared word; busywait rises in the request cycle
    start(1'b1, 1'b0, 6'd10, 32'h0, 1'b1, 32'h0);
    #1;
    chk("busywait_comb_rise", 32'(bw0_s), 32'd1);
    wait_done();
    release_req();
    chk("idle_after_done", 32'(bw0_s), 32'd0);

    // Write then read back, neighbour untouched
    access(1'b0, 6'd37, 32'hDEADBEEF, 32'h0);
    access(1'b1, 6'd37, 32'h0, 32'hDEADBEEF);
    access(1'b1, 6'd36, 32'h0, 32'h0);

    // Eviction: write-back then fetch, each request held through its DONE
    start(1'b0, 1'b1, 6'd5, 32'h11223344, 1'b1, 32'h0);
    wait_done();
    chk("evict_done_low", 32'(bw0_s), 32'd0);
    start(1'b1, 1'b0, 6'd13, 32'h0, 1'b1, 32'h0);
    #1;
    chk("done_ignores_read", 32'(bw0_s), 32'd0);
    tick();
    chk("fetch_starts_after_done", 32'(bw0_s), 32'd1);
    wait_done();
    tick();
    read_s = 1'b0;
    tick();
    chk("no_third_access", 32'(bw0_s), 32'd0);
    access(1'b1, 6'd5, 32'h0, 32'h11223344);

    // Inputs changing mid-access are ignored
    start(1'b0, 1'b1, 6'd2, 32'h000000AA, 1'b1, 32'h0);
    tick();
    addr_s  = 6'd3;
    wdata_s = 32'h000000BB;
    wait_done();
    release_req();
    access(1'b1, 6'd2, 32'h0, 32'h000000AA);
    access(1'b1, 6'd3, 32'h0, 32'h0);

    // Conflicting READ and WRITE
    start(1'b1, 1'b1, 6'd37, 32'h0, 1'b0, 32'h0);
    #1;
    chk("conflict_busywait", 32'(bw0_s), 32'd0);
    tick();
    read_s  = 1'b0;
    write_s = 1'b0;
    chk("conflict_err_pulse", 32'(err0_s), 32'd1);
    tick();
    chk("conflict_err_clears", 32'(err0_s), 32'd0);
    access(1'b1, 6'd37, 32'h0, 32'hDEADBEEF);

    // Reset during BUSY drops the pending write
    start(1'b0, 1'b1, 6'd9, 32'h00000055, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    rst0_s  = 1'b1;
    write_s = 1'b0;
    #1;
    chk("busywait_low_in_reset", 32'(bw0_s), 32'd0);
    tick();
    rst0_s = 1'b0;
    chk("busywait_after_abort", 32'(bw0_s), 32'd0);
    chk("readdata_after_abort", rdata0_s, 32'h0);
    access(1'b1, 6'd9, 32'h0, 32'h0);
    access(1'b1, 6'd37, 32'h0, 32'h0);

    // LATENCY=1 instance
    rst0_s = 1'b1;
    sel_s  = 1'b1;
    tick();
    rst1_s = 1'b0;
    tick();
    access(1'b0, 6'd9, 32'h00000055, 32'h0);
    access(1'b1, 6'd9, 32'h0, 32'h00000055);
    access(1'b1, 6'd10, 32'h0, 32'h0);
    tick();

    chk("queue_l5_drained", 32'(q0.size()), 32'd0);
    chk("queue_l1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
